uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Configurable UART receiver for the GPS/serial input path, replacing the fixed 8N1 receiver. It supports 5–9 data bits, optional odd/even parity, and 1 or 2 stop bits. Each bit is decided by 3-sample majority voting, and the block flags false-start, framing, parity, break and overrun conditions. Received words go into a small FIFO and are presented to downstream NMEA/packet logic over a valid/ready stream.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency
- BAUD_RATE, 9600, line rate
- DATA_BITS, 8, data bits per frame; legal range 5–9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 4, received-word buffer depth; power of two, ≥2
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_in  in  1  asynchronous serial line, idle high
- m_data  out  DATA_BITS  head-of-FIFO data word, LSB = first bit received
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer accepts the head word when high with m_valid
- parity_err  out  1  parity error flag for the head word; 0 when PARITY = 0
- frame_err  out  1  stop bit sampled low for the head word
- overrun  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full
- break_det  out  1  one-cycle pulse on break detection

## Operation
- Line synchroniser: 3 flops, reset to 1. rx is the last stage.
- BAUD_TICK = CLK_FREQ_HZ/BAUD_RATE (integer division); HALF = BAUD_TICK/2.
- Elaboration error if BAUD_TICK < 8 or if any parameter is outside its legal range.
- Bit counter width is $clog2(BAUD_TICK). It counts 0..BAUD_TICK-1 within each bit.
- Sampling: rx is captured at counts HALF-1, HALF and HALF+1. The bit value is the majority of the three, decided at count HALF+1.
- States:
  - IDLE: rx==0 → START, counter 0.
  - START: majority 1 → IDLE (false start, nothing reported). Majority 0 → continue. At count BAUD_TICK-1 → DATA, counter 0.
  - DATA: one decision per bit, shifted in LSB-first. After bit DATA_BITS-1 → PARITY if PARITY≠0, else STOP.
  - PARITY: compare the majority bit against the odd/even parity of the data; mismatch sets the word's parity_err.
  - STOP: one decision per stop bit. Any stop decision of 0 sets frame_err. At the last stop bit's decision (mid-bit, not end-of-bit) the frame completes → IDLE. This gives half a bit of resync margin.
- Break: data all 0, parity bit 0 (if present) and the first stop bit 0.
  - Pulse break_det, do not enqueue, enter BRK_WAIT.
  - BRK_WAIT → IDLE when rx==1.
- Completed non-break frame: push {parity_err, frame_err, data} into the FIFO. Words with errors are still enqueued, carrying their flags.
- FIFO full at push: the word is dropped and overrun pulses. Exception: a same-cycle pop (m_valid & m_ready) frees a slot, so the push is accepted and overrun stays 0.
- Reset mid-frame: the partial frame is discarded, the FIFO is emptied, and the block returns to IDLE.

## Timing
- Reset values: m_valid 0, m_data 0, parity_err 0, frame_err 0, overrun 0, break_det 0, state IDLE, FIFO pointers 0.
- rx_in falling edge reaches rx after 3 clk; IDLE exits on that cycle.
- Start-bit majority is decided HALF+1 cycles after entering START.
- Successive bit decisions are exactly BAUD_TICK cycles apart.
- The push occurs on the clock edge ending the last-stop-decision cycle. m_valid, m_data and the flags are valid on the following cycle.
- Total latency from rx_in start edge to m_valid: 3 + (1+DATA_BITS+P+STOP_BITS-1)·BAUD_TICK + HALF+3 cycles, where P = 1 if PARITY≠0, else 0.
- Pop happens on the edge where m_valid & m_ready. m_data, m_valid and the flags update on the next cycle.
- m_data and the flags are stable while m_valid & !m_ready.
- overrun and break_det are high for exactly one cycle per event.

## Structure
- Package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants
  - rx state encoding (IDLE, START, DATA, PARITY, STOP, BRK_WAIT)
  - function baud_tick(clk_hz, baud)
- Sub-module sync_fifo (WIDTH = DATA_BITS+2, DEPTH = FIFO_DEPTH) provides registered storage, full/empty outputs and simultaneous push/pop.

## Test plan
Bench parameters: CLK_FREQ_HZ = 1_000_000, BAUD_RATE = 62_500, so BAUD_TICK = 16.
- 8N1, send 0xA5, m_ready=1 → m_data=0xA5, flags 0, m_valid high for exactly 1 cycle.
- PARITY=2, send 0x07 with parity bit 0 → m_data=0x07, parity_err=1, frame_err=0. Repeat with parity bit 1 → parity_err=0.
- 8N1, send 0x3C with stop bit 0 → m_data=0x3C, frame_err=1. With STOP_BITS=2 and the second stop bit 0 → frame_err=1.
- Idle line glitched low for 4 cycles → no m_valid, back to IDLE. A 1-cycle noise spike inside a data bit of 0x55 → still 0x55.
- m_ready=0, send 0x01..0x05 with FIFO_DEPTH=4 → overrun pulses once (on 0x05). Drain yields 0x01..0x04.
- Line low for 20 bit times, then high, then send 0x55 → one break_det pulse, nothing enqueued, then m_data=0x55. Assert rst mid-frame → no output, the next byte is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART receiver: parity modes, rx FSM encoding
// and the baud divider helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_PARITY   = 3'd3;
  localparam logic [2:0] ST_STOP     = 3'd4;
  localparam logic [2:0] ST_BRK_WAIT = 3'd5;

  function automatic int unsigned baud_tick(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sync_fifo.sv
// Registered-storage FIFO with full/empty flags; a pop in the same cycle lets a push into a
// full FIFO succeed.
module sync_fifo import uart_pkg::*; #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        wr_ptr_q                <= wr_ptr_q + PtrOne;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, optional parity, 1-2 stop bits, 3-sample
// majority per bit, error/break detection, and a small output FIFO on a valid/ready stream.
module uart_rx_cfg import uart_pkg::*; #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int unsigned BaudTick = baud_tick(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned Half     = BaudTick / 2;
  localparam int unsigned CntW     = $clog2(BaudTick);
  localparam int unsigned Width    = DATA_BITS + 2;

  localparam logic [CntW-1:0] CntLast = CntW'(BaudTick - 1);
  localparam logic [CntW-1:0] CntS0   = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntS1   = CntW'(Half);
  localparam logic [CntW-1:0] CntDec  = CntW'(Half + 1);
  localparam logic [CntW-1:0] CntOne  = 1;
  localparam logic [3:0]      BitLast  = 4'(DATA_BITS - 1);
  localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);

  if (BaudTick < 8) begin : g_err_baud
    $error("BAUD_TICK must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_bits
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_err_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic [2:0]           sync_q;
  logic                 rx;
  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;
  logic                 maj, dec, cnt_wrap, par_exp, brk_cond;
  logic                 push, pop, full, empty;
  logic [Width-1:0]     push_data, head;

  assign rx       = sync_q[2];
  assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx) | (samp_q[1] & rx);
  assign dec      = (cnt_q == CntDec);
  assign cnt_wrap = (cnt_q == CntLast);
  assign par_exp  = (PARITY == PARITY_ODD) ? ~^shift_q : ^shift_q;
  assign brk_cond = (shift_q == '0) && (PARITY == PARITY_NONE || !par_bit_q) && !maj;

  assign pop       = m_valid & m_ready;
  assign push_data = {perr_q, ferr_q | ~maj, shift_q};
  assign ovr_d     = push & full & ~pop;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    samp_d    = samp_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    brk_d     = 1'b0;
    push      = 1'b0;

    if (state_q != ST_IDLE && state_q != ST_BRK_WAIT) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + CntOne;
      if (cnt_q == CntS0) samp_d[0] = rx;
      if (cnt_q == CntS1) samp_d[1] = rx;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx) begin
          state_d = ST_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (dec && maj) state_d = ST_IDLE;
        else if (cnt_wrap) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (dec) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (cnt_wrap) begin
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (dec) begin
          par_bit_d = maj;
          perr_d    = (maj != par_exp);
        end
        if (cnt_wrap) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (dec) begin
          if (!maj) ferr_d = 1'b1;
          if (bit_q == 4'd0 && brk_cond) begin
            brk_d   = 1'b1;
            state_d = ST_BRK_WAIT;
          end else if (bit_q == StopLast) begin
            // Complete at mid-bit so the next start edge has half a bit of margin.
            push    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        if (cnt_wrap) bit_d = bit_q + 4'd1;
      end
      ST_BRK_WAIT: begin
        if (rx) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 3'b111;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      samp_q    <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], rx_in};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      samp_q    <= samp_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
      ovr_q     <= ovr_d;
    end
  end

  sync_fifo #(
    .WIDTH (Width),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign {parity_err, frame_err, m_data} = head;
  assign m_valid   = ~empty;
  assign overrun   = ovr_q;
  assign break_det = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_cfg;

  localparam int BT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      rxl, rdy, mv, pe, fe, ovr, brk;
  logic [2:0][7:0] md;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcnt [3] = '{0, 0, 0};
  int ocnt [3] = '{0, 0, 0};
  int bcnt [3] = '{0, 0, 0};
  int t_start = 0;
  int t_valid0 = 0;
  bit seen0 = 1'b0;
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  logic [9:0] q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(62_500), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .rx_in(rxl[0]), .m_data(md[0]), .m_valid(mv[0]), .m_ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ovr[0]), .break_det(brk[0]));

  uart_rx_cfg #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(62_500), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .rx_in(rxl[1]), .m_data(md[1]), .m_valid(mv[1]), .m_ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ovr[1]), .break_det(brk[1]));

  uart_rx_cfg #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(62_500), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .rx_in(rxl[2]), .m_data(md[2]), .m_valid(mv[2]), .m_ready(rdy[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ovr[2]), .break_det(brk[2]));

  // Sample 1 time unit after the falling edge, after any same-edge input changes settle.
  always @(negedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      if (mv[d]) vcnt[d]++;
      if (ovr[d]) ocnt[d]++;
      if (brk[d]) bcnt[d]++;
      if (mv[d] && rdy[d]) begin
        case (d)
          0: q0.push_back({pe[d], fe[d], md[d]});
          1: q1.push_back({pe[d], fe[d], md[d]});
          default: q2.push_back({pe[d], fe[d], md[d]});
        endcase
      end
    end
    if (mv[0] && !seen0) begin
      seen0    = 1'b1;
      t_valid0 = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input int d, input logic v, input bit spike);
    for (int c = 0; c < BT; c++) begin
      rxl[d] = (spike && c == 9) ? ~v : v;
      @(negedge clk);
    end
  endtask

  // Instance 1 carries a parity bit, instance 2 has two stop bits.
  task automatic send(input int d, input logic [7:0] data, input logic par,
                      input logic [1:0] stop, input int spike_bit);
    t_start = cyc;
    drive_bit(d, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d, data[i], i == spike_bit);
    if (d == 1) drive_bit(d, par, 1'b0);
    drive_bit(d, stop[0], 1'b0);
    if (d == 2) drive_bit(d, stop[1], 1'b0);
    rxl[d] = 1'b1;
    repeat (3 * BT) @(negedge clk);
  endtask

  task automatic get_word(input int d, output logic [31:0] w);
    bit ok = 1'b0;
    w = 32'hDEAD;
    for (int t = 0; t < 64 && !ok; t++) begin
      case (d)
        0: if (q0.size() > 0) begin w = 32'(q0.pop_front()); ok = 1'b1; end
        1: if (q1.size() > 0) begin w = 32'(q1.pop_front()); ok = 1'b1; end
        default: if (q2.size() > 0) begin w = 32'(q2.pop_front()); ok = 1'b1; end
      endcase
      if (!ok) @(negedge clk);
    end
  endtask

  typedef struct {
    int         d;
    logic [7:0] data;
    logic       par;
    logic [1:0] stop;
    int         spike;
    logic [9:0] exp;  // {parity_err, frame_err, data}
  } vec_t;

  vec_t tbl [10];
  logic [31:0] w;
  int base;

  initial begin
    tbl[0] = '{0, 8'hA5, 1'b0, 2'b11, -1, 10'h0A5};
    tbl[1] = '{0, 8'h3C, 1'b0, 2'b10, -1, 10'h13C};
    tbl[2] = '{1, 8'h07, 1'b0, 2'b11, -1, 10'h207};
    tbl[3] = '{1, 8'h07, 1'b1, 2'b11, -1, 10'h007};
    tbl[4] = '{2, 8'h81, 1'b0, 2'b01, -1, 10'h181};
    tbl[5] = '{2, 8'h81, 1'b0, 2'b11, -1, 10'h081};
    tbl[6] = '{1, 8'hFF, 1'b0, 2'b11, -1, 10'h0FF};
    tbl[7] = '{0, 8'h55, 1'b0, 2'b11, 3, 10'h055};
    tbl[8] = '{1, 8'h80, 1'b0, 2'b11, -1, 10'h280};
    tbl[9] = '{0, 8'h00, 1'b0, 2'b11, -1, 10'h000};

    rst = 1'b1;
    rxl = 3'b111;
    rdy = 3'b111;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_m_valid", 32'(mv), 32'h0);
    check("reset_m_data", 32'(md[0]), 32'h0);
    check("reset_flags", 32'({pe, fe}), 32'h0);
    check("reset_pulses", 32'({ovr, brk}), 32'h0);

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].d, tbl[i].data, tbl[i].par, tbl[i].stop, tbl[i].spike);
      get_word(tbl[i].d, w);
      check($sformatf("vec%0d_word", i), w, 32'(tbl[i].exp));
      if (i == 0) begin
        check("first_latency", 32'(t_valid0 - t_start), 32'd158);
        check("valid_one_cycle", 32'(vcnt[0]), 32'd1);
      end
    end

    // Short low glitch on an idle line must be rejected as a false start.
    base = vcnt[0];
    rxl[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxl[0] = 1'b1;
    repeat (3 * BT) @(negedge clk);
    check("glitch_no_valid", 32'(vcnt[0] - base), 32'd0);

    // Break: line low for 20 bit times.
    base = bcnt[0];
    rxl[0] = 1'b0;
    repeat (20 * BT) @(negedge clk);
    rxl[0] = 1'b1;
    repeat (3 * BT) @(negedge clk);
    check("break_pulse", 32'(bcnt[0] - base), 32'd1);
    check("break_no_word", 32'(q0.size()), 32'd0);
    send(0, 8'h55, 1'b0, 2'b11, -1);
    get_word(0, w);
    check("after_break_word", w, 32'h055);

    // Overrun: four words fill the FIFO, the fifth is dropped.
    base = ocnt[0];
    rdy[0] = 1'b0;
    for (int k = 1; k <= 4; k++) send(0, 8'(k), 1'b0, 2'b11, -1);
    check("no_overrun_yet", 32'(ocnt[0] - base), 32'd0);
    send(0, 8'h05, 1'b0, 2'b11, -1);
    check("overrun_once", 32'(ocnt[0] - base), 32'd1);
    check("head_stable", 32'({mv[0], md[0]}), 32'h101);
    rdy[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      get_word(0, w);
      check($sformatf("drain%0d", k), w, 32'(k));
    end
    repeat (2 * BT) @(negedge clk);
    check("drained_empty", 32'({mv[0], 1'b0} | 2'(q0.size())), 32'h0);

    // Reset in the middle of a frame discards it.
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, i[0], 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rxl[0] = 1'b1;
    @(negedge clk);
    check("midreset_valid", 32'(mv[0]), 32'h0);
    repeat (3 * BT) @(negedge clk);
    check("midreset_no_word", 32'(q0.size()), 32'd0);
    send(0, 8'hC3, 1'b0, 2'b11, -1);
    get_word(0, w);
    check("after_reset_word", w, 32'h0C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
